// File: rtl/memcore_port_pkg.sv
// Shared types and sizing helpers for the memcore stream port and its response FIFO.
package memcore_port_pkg;

    localparam int REQ_DATA_WIDTH    = 32;
    localparam int REQ_ADDRESS_WIDTH = 6;

    typedef struct packed {
        logic                         we;
        logic [REQ_ADDRESS_WIDTH-1:0] addr;
        logic [REQ_DATA_WIDTH-1:0]    data;
    } req_t;

    // Occupancy counter must be able to hold the value DEPTH itself.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/memcore_resp_fifo.sv
// Register-based first-word-fall-through FIFO holding read responses from the memory core.
module memcore_resp_fifo
    import memcore_port_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    localparam int CW        = count_width(DEPTH),
    localparam int PW        = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [CW-1:0]         count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] entry_reg [DEPTH];
    logic [PW-1:0]         wr_ptr_reg;
    logic [PW-1:0]         rd_ptr_reg;
    logic [CW-1:0]         count_reg;
    logic                  pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop_ok = pop & (count_reg != '0);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    entry_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop_ok) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop_ok);
        end
    end

    assign count     = count_reg;
    assign head_data = entry_reg[rd_ptr_reg];

endmodule

// File: rtl/memcore_stream_port.sv
// Valid/ready request stream to URAM port adapter with credit-managed response FIFO.
// Optional address bounds checking is enabled by defining MEMCORE_STREAM_PORT_BOUNDS_CHECK_EN.
module memcore_stream_port
    import memcore_port_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 6,
    parameter int ADDRESS_RANGE = 64,
    parameter int RESP_DEPTH    = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic                     mem_ce,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_d,
    input  logic [DATA_WIDTH-1:0]    mem_q,
    output logic                     idle,
    output logic                     err
);

    localparam int CW = count_width(RESP_DEPTH);

    logic                  run_reg;
    logic                  inflight_reg;
    logic [CW-1:0]         count;
    logic                  pop;
    logic                  fire;
    logic                  rd_fire;
    logic                  credit_ok;
    logic [DATA_WIDTH-1:0] push_data;

    // A read may only launch if its response is guaranteed a FIFO slot.
    assign pop        = resp_valid & resp_ready;
    assign credit_ok  = ({1'b0, count} + (CW + 1)'(inflight_reg))
                        < ((CW + 1)'(RESP_DEPTH) + (CW + 1)'(pop));
    assign req_ready  = run_reg & (req_we | credit_ok);
    assign fire       = req_valid & req_ready;
    assign rd_fire    = fire & ~req_we;
    assign resp_valid = (count != '0);
    assign idle       = ~inflight_reg & (count == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_reg      <= 1'b0;
            inflight_reg <= 1'b0;
        end else begin
            run_reg      <= 1'b1;
            inflight_reg <= rd_fire;
        end
    end

`ifdef MEMCORE_STREAM_PORT_BOUNDS_CHECK_EN
    logic in_range;
    logic inflight_bad_reg;
    logic err_reg;

    assign in_range = ({1'b0, req_addr} < (ADDRESS_WIDTH + 1)'(ADDRESS_RANGE));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_bad_reg <= 1'b0;
            err_reg          <= 1'b0;
        end else begin
            inflight_bad_reg <= rd_fire & ~in_range;
            err_reg          <= err_reg | (fire & ~in_range);
        end
    end

    // Out-of-range reads still occupy their slot so response order is kept.
    assign mem_ce    = fire & in_range;
    assign push_data = inflight_bad_reg ? '0 : mem_q;
    assign err       = err_reg;
`else
    logic unused_range;
    assign unused_range = (ADDRESS_RANGE != 0);
    assign mem_ce       = fire;
    assign push_data    = mem_q;
    assign err          = 1'b0;
`endif

    assign mem_we      = mem_ce & req_we;
    assign mem_address = req_addr;
    assign mem_d       = req_data;

    memcore_resp_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RESP_DEPTH)
    ) u_resp_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (inflight_reg),
        .push_data(push_data),
        .pop      (pop),
        .count    (count),
        .head_data(resp_data)
    );

endmodule

// File: tb/tb_memcore_stream_port.sv
// Directed and randomised bench for memcore_stream_port with a 1-cycle-latency memory model.
module tb_memcore_stream_port;
    import memcore_port_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 6;
`ifdef MEMCORE_STREAM_PORT_BOUNDS_CHECK_EN
    localparam int RANGE = 48;
`else
    localparam int RANGE = 64;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] mem_address;
    logic          mem_ce;
    logic          mem_we;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_q;
    logic          idle;
    logic          err;

    int n_checks = 0;
    int n_pass   = 0;

    memcore_stream_port #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .ADDRESS_RANGE(RANGE),
        .RESP_DEPTH   (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .mem_address(mem_address),
        .mem_ce     (mem_ce),
        .mem_we     (mem_we),
        .mem_d      (mem_d),
        .mem_q      (mem_q),
        .idle       (idle),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Memory core: registered read, one cycle latency.
    bit [DW-1:0] core_mem [64];
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) core_mem[mem_address] <= mem_d;
            else        mem_q <= core_mem[mem_address];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Scoreboard: reference memory and expected response queue, sampled mid-cycle.
    bit   [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_q [$];
    always @(negedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
        end else begin
            if (resp_valid && resp_ready) begin
                check("resp_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("resp_data", resp_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
            if (req_valid && req_ready) begin
                if (req_we) begin
                    if (int'(req_addr) < RANGE) ref_mem[req_addr] <= req_data;
                end else begin
                    exp_q.push_back((int'(req_addr) < RANGE) ? ref_mem[req_addr] : '0);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_data  = d;
    endtask

    task automatic wait_idle(input string tag);
        int c;
        for (c = 0; c < 64; c++) begin
            @(negedge clk);
            if (idle) break;
        end
        check(tag, 32'(idle), 32'd1);
        step();
    endtask

    initial begin
        int accepts;
        int k;
        int issued;
        int cyc;
        req_t r;

        reset_n    = 1'b0;
        resp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("phase reset");
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_mem_ce", 32'(mem_ce), 32'd0);
        reset_n = 1'b1;
        #1;
        check("ready_before_edge", 32'(req_ready), 32'd0);
        step();
        check("ready_after_edge", 32'(req_ready), 32'd1);

        $display("phase write-then-read addr 5");
        drive(1'b1, 1'b1, 6'd5, 32'hDEADBEEF);
        @(negedge clk);
        check("wr_mem_ce", 32'(mem_ce), 32'd1);
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_address", 32'(mem_address), 32'd5);
        check("wr_mem_d", mem_d, 32'hDEADBEEF);
        step();
        drive(1'b1, 1'b0, 6'd5, '0);
        @(negedge clk);
        check("rd_mem_ce", 32'(mem_ce), 32'd1);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rd_lat_n1_valid", 32'(resp_valid), 32'd0);
        check("rd_lat_n1_idle", 32'(idle), 32'd0);
        step();
        @(negedge clk);
        check("rd_lat_n2_valid", 32'(resp_valid), 32'd1);
        check("rd_lat_n2_data", resp_data, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("rd_idle_back", 32'(idle), 32'd1);
        step();

        $display("phase preload 0..15");
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i * 3));
            step();
        end

        $display("phase back-to-back reads");
        for (int i = 0; i < 18; i++) begin
            if (i < 16) drive(1'b1, 1'b0, AW'(i), '0);
            else        drive(1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (i < 16) check("b2b_req_ready", 32'(req_ready), 32'd1);
            if (i >= 2) begin
                check("b2b_resp_valid", 32'(resp_valid), 32'd1);
                check("b2b_resp_data", resp_data, 32'((i - 2) * 3));
            end
            step();
        end
        @(negedge clk);
        check("b2b_idle", 32'(idle), 32'd1);
        step();

        $display("phase back-pressure");
        resp_ready = 1'b0;
        accepts    = 0;
        k          = 0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, AW'(k), '0);
            @(negedge clk);
            if (req_ready) begin
                accepts++;
                k++;
            end
            step();
        end
        check("bp_accepts", 32'(accepts), 32'd2);
        drive(1'b1, 1'b0, AW'(k), '0);
        @(negedge clk);
        check("bp_read_blocked", 32'(req_ready), 32'd0);
        step();
        drive(1'b1, 1'b1, 6'd20, 32'h0000_1234);
        @(negedge clk);
        check("bp_write_ready", 32'(req_ready), 32'd1);
        step();
        resp_ready = 1'b1;
        for (int a = k; a < 16; a++) begin
            drive(1'b1, 1'b0, AW'(a), '0);
            @(negedge clk);
            check("bp_resume_ready", 32'(req_ready), 32'd1);
            if (a == k)     check("bp_drain0", resp_data, 32'd0);
            if (a == k + 1) check("bp_drain1", resp_data, 32'd3);
            step();
        end
        drive(1'b0, 1'b0, '0, '0);
        wait_idle("bp_idle");

        $display("phase reset mid-flight");
        drive(1'b1, 1'b0, 6'd7, '0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        reset_n = 1'b0;
        #1;
        check("mr_resp_valid", 32'(resp_valid), 32'd0);
        check("mr_idle", 32'(idle), 32'd1);
        check("mr_req_ready", 32'(req_ready), 32'd0);
        check("mr_resp_data", resp_data, 32'd0);
        step();
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk);
            check("mr_no_resp", 32'(resp_valid), 32'd0);
        end
        step();

`ifdef MEMCORE_STREAM_PORT_BOUNDS_CHECK_EN
        $display("phase bounds check");
        check("bc_err_clear", 32'(err), 32'd0);
        drive(1'b1, 1'b0, 6'd50, '0);
        @(negedge clk);
        check("bc_rd_ready", 32'(req_ready), 32'd1);
        check("bc_rd_mem_ce", 32'(mem_ce), 32'd0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("bc_err_set", 32'(err), 32'd1);
        step();
        @(negedge clk);
        check("bc_resp_valid", 32'(resp_valid), 32'd1);
        check("bc_resp_zero", resp_data, 32'd0);
        step();
        drive(1'b1, 1'b1, 6'd63, 32'hFFFF_FFFF);
        @(negedge clk);
        check("bc_wr_mem_ce", 32'(mem_ce), 32'd0);
        step();
        drive(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("bc_err_hold", 32'(err), 32'd1);
        step();
`endif

        $display("phase random mix");
        issued = 0;
        for (cyc = 0; cyc < 40000 && issued < 10000; cyc++) begin
            r.we   = 1'($urandom_range(0, 1));
            r.addr = AW'($urandom_range(0, 63));
            r.data = $urandom;
            drive(($urandom_range(0, 99) < 70), r.we, r.addr, r.data);
            resp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (req_valid && req_ready) issued++;
            step();
        end
        drive(1'b0, 1'b0, '0, '0);
        resp_ready = 1'b1;
        wait_idle("rand_idle");
        check("rand_issued", 32'(issued), 32'd10000);
        check("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
